// File: rtl/pilha_param.sv
// -----------------------------------------------------------------------------
// pilha_param -- parameterised LIFO stack with a registered pop port
//
// Entries live in a DEPTH x WIDTH array addressed by the fill count: the next
// push lands in entry[count] and the current top is entry[count-1]. A pop
// returns the old top on data_out one clock later, with a one-cycle pop_valid
// strobe. A simultaneous push+pop swaps the top in place, and passes data_in
// straight through when the stack is empty. Refused operations set sticky
// error flags that stay set until err_clr.
//
// Parameters
//   WIDTH     data word width in bits (>= 1)
//   DEPTH     number of stack entries (>= 2)
//   AF_LEVEL  count at or above which almost_full asserts
//
// Ports
//   clk          clock, all state changes on the rising edge
//   rst_n        asynchronous active-low reset
//   push         write data_in onto the top
//   pop          remove the top entry
//   clear        synchronous flush; wins over push/pop
//   err_clr      synchronous clear of overflow/underflow
//   data_in      word to push
//   data_out     registered word returned by the last accepted pop
//   pop_valid    one-cycle strobe: data_out was updated this cycle
//   top          combinational peek of the top entry, 0 when empty
//   count        number of stored entries, 0..DEPTH
//   empty        count == 0
//   full         count == DEPTH
//   almost_full  count >= AF_LEVEL
//   overflow     sticky: a push was refused while full
//   underflow    sticky: a pop was refused while empty
// -----------------------------------------------------------------------------
module pilha_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           push,
  input  logic                           pop,
  input  logic                           clear,
  input  logic                           err_clr,
  input  logic [WIDTH-1:0]               data_in,
  output logic [WIDTH-1:0]               data_out,
  output logic                           pop_valid,
  output logic [WIDTH-1:0]               top,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           empty,
  output logic                           full,
  output logic                           almost_full,
  output logic                           overflow,
  output logic                           underflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [CW-1:0]    cnt_p1;
  logic [WIDTH-1:0] data_out_p1;
  logic             vld_p1;
  logic             ovf_p1;
  logic             udf_p1;

  logic             is_empty;
  logic             is_full;
  logic [AW-1:0]    top_idx;
  logic [AW-1:0]    wr_idx;
  logic [WIDTH-1:0] top_word;

  logic             op_push;
  logic             op_pop;
  logic             op_swap;
  logic             op_pass;
  logic             pop_acc;
  logic             mem_we;
  logic             ovf_evt;
  logic             udf_evt;
  logic [WIDTH-1:0] pop_data;

  // Count update kept inside 0..DEPTH even if the decode were ever widened:
  // an increment at DEPTH or a decrement at 0 holds the value instead of
  // wrapping the pointer.
  function automatic logic [CW-1:0] cnt_next(input logic [CW-1:0] cur,
                                             input logic            inc,
                                             input logic            dec);
    logic [CW-1:0] nxt;
    nxt = cur;
    if (inc && !dec && (cur != CW'(DEPTH)))
      nxt = cur + CW'(1);
    else if (dec && !inc && (cur != '0))
      nxt = cur - CW'(1);
    return nxt;
  endfunction

  // ---- stage 0: status and operation decode from the current count ----
  assign is_empty = (cnt_p1 == '0);
  assign is_full  = (cnt_p1 == CW'(DEPTH));
  assign top_idx  = AW'(cnt_p1 - CW'(1));
  assign top_word = mem[top_idx];

  always_comb begin
    op_push = 1'b0;
    op_pop  = 1'b0;
    op_swap = 1'b0;
    op_pass = 1'b0;
    ovf_evt = 1'b0;
    udf_evt = 1'b0;
    if (!clear) begin
      op_push = push && !pop && !is_full;
      op_pop  = pop && !push && !is_empty;
      op_swap = push && pop && !is_empty;
      op_pass = push && pop && is_empty;
      ovf_evt = push && !pop && is_full;
      udf_evt = pop && !push && is_empty;
    end
  end

  assign pop_acc  = op_pop || op_swap || op_pass;
  assign pop_data = op_pass ? data_in : top_word;

  // A swap rewrites the current top; a plain push fills the next free slot.
  // The write is also held off while reset is asserted so an edge that
  // coincides with reset cannot land a half-finished operation in the array.
  assign mem_we = rst_n && (op_push || op_swap);
  assign wr_idx = op_swap ? top_idx : AW'(cnt_p1);

  // ---- stage 1: registered state, pop result and error flags ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_p1      <= '0;
      data_out_p1 <= '0;
      vld_p1      <= 1'b0;
      ovf_p1      <= 1'b0;
      udf_p1      <= 1'b0;
    end else begin
      vld_p1 <= pop_acc;
      if (pop_acc)
        data_out_p1 <= pop_data;
      if (clear)
        cnt_p1 <= '0;
      else
        cnt_p1 <= cnt_next(cnt_p1, op_push, op_pop);
      // A new error in the same cycle as err_clr wins, so no event is lost.
      ovf_p1 <= (ovf_p1 && !err_clr) || ovf_evt;
      udf_p1 <= (udf_p1 && !err_clr) || udf_evt;
    end
  end

  // Storage is not reset; only entries below count are ever observable.
  always_ff @(posedge clk) begin
    if (mem_we)
      mem[wr_idx] <= data_in;
  end

  assign data_out    = data_out_p1;
  assign pop_valid   = vld_p1;
  assign count       = cnt_p1;
  assign empty       = is_empty;
  assign full        = is_full;
  assign almost_full = (cnt_p1 >= CW'(AF_LEVEL));
  assign top         = is_empty ? '0 : top_word;
  assign overflow    = ovf_p1;
  assign underflow   = udf_p1;

endmodule

// File: tb/tb_pilha_param.sv
// -----------------------------------------------------------------------------
// tb_pilha_param -- self-checking bench for pilha_param
//
// Two instances: A (WIDTH=8, DEPTH=8, default AF_LEVEL) and B (WIDTH=16,
// DEPTH=4, AF_LEVEL=2). A queue-based reference stack predicts count, flags,
// top and data_out after every operation; each accepted pop pushes its
// expected word onto a per-instance scoreboard that a monitor pops when the
// DUT raises pop_valid one cycle later.
// -----------------------------------------------------------------------------
module tb_pilha_param;

  localparam int DA = 8, AFA = 7;
  localparam int DB = 4, AFB = 2;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        a_push, a_pop, a_clear, a_errclr;
  logic [7:0]  a_din, a_dout, a_top;
  logic        a_pv, a_empty, a_full, a_af, a_ovf, a_udf;
  logic [3:0]  a_cnt;

  logic        b_push, b_pop, b_clear, b_errclr;
  logic [15:0] b_din, b_dout, b_top;
  logic        b_pv, b_empty, b_full, b_af, b_ovf, b_udf;
  logic [2:0]  b_cnt;

  int checks = 0;
  int errors = 0;

  logic [15:0] sb_a[$];
  logic [15:0] sb_b[$];

  logic [15:0] m_a[$];
  logic [15:0] m_b[$];
  logic        ov_a, ud_a, ov_b, ud_b;
  logic [15:0] do_a, do_b;

  always #5 clk = ~clk;

  pilha_param #(.WIDTH(8), .DEPTH(DA)) u_a (
    .clk(clk), .rst_n(rst_n), .push(a_push), .pop(a_pop), .clear(a_clear),
    .err_clr(a_errclr), .data_in(a_din), .data_out(a_dout), .pop_valid(a_pv),
    .top(a_top), .count(a_cnt), .empty(a_empty), .full(a_full),
    .almost_full(a_af), .overflow(a_ovf), .underflow(a_udf)
  );

  pilha_param #(.WIDTH(16), .DEPTH(DB), .AF_LEVEL(AFB)) u_b (
    .clk(clk), .rst_n(rst_n), .push(b_push), .pop(b_pop), .clear(b_clear),
    .err_clr(b_errclr), .data_in(b_din), .data_out(b_dout), .pop_valid(b_pv),
    .top(b_top), .count(b_cnt), .empty(b_empty), .full(b_full),
    .almost_full(b_af), .overflow(b_ovf), .underflow(b_udf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard monitors: one cycle after an accepted pop the strobe and the
  // word must appear; in any other cycle the strobe must stay low.
  always @(posedge clk) begin
    #1;
    if (sb_a.size() > 0) begin
      chk("a_pop_valid", {31'b0, a_pv}, 32'd1);
      chk("a_data_out", {24'b0, a_dout}, {16'b0, sb_a.pop_front()});
    end else begin
      chk("a_pop_valid_idle", {31'b0, a_pv}, 32'd0);
    end
  end

  always @(posedge clk) begin
    #1;
    if (sb_b.size() > 0) begin
      chk("b_pop_valid", {31'b0, b_pv}, 32'd1);
      chk("b_data_out", {16'b0, b_dout}, {16'b0, sb_b.pop_front()});
    end else begin
      chk("b_pop_valid_idle", {31'b0, b_pv}, 32'd0);
    end
  end

  task automatic check_reset_outputs();
    chk("rst_a_count", {28'b0, a_cnt}, 32'd0);
    chk("rst_a_data_out", {24'b0, a_dout}, 32'd0);
    chk("rst_a_pop_valid", {31'b0, a_pv}, 32'd0);
    chk("rst_a_flags", {27'b0, a_empty, a_full, a_af, a_ovf, a_udf}, 32'b10000);
    chk("rst_a_top", {24'b0, a_top}, 32'd0);
    chk("rst_b_count", {29'b0, b_cnt}, 32'd0);
    chk("rst_b_data_out", {16'b0, b_dout}, 32'd0);
    chk("rst_b_pop_valid", {31'b0, b_pv}, 32'd0);
    chk("rst_b_flags", {27'b0, b_empty, b_full, b_af, b_ovf, b_udf}, 32'b10000);
    chk("rst_b_top", {16'b0, b_top}, 32'd0);
  endtask

  task automatic model_reset();
    m_a.delete(); m_b.delete();
    ov_a = 1'b0; ud_a = 1'b0; ov_b = 1'b0; ud_b = 1'b0;
    do_a = '0;   do_b = '0;
  endtask

  // Drive one operation on instance A (sel=0) or B (sel=1), update the
  // reference stack, then check the registered state after the edge.
  task automatic op(input bit sel, input bit ph, input bit pp, input bit cl,
                    input bit ec, input logic [15:0] d);
    logic [15:0] st[$];
    logic [15:0] dv, e, dout;
    logic        ov, ud;
    int          dep, af;
    if (sel) begin
      st = m_b; ov = ov_b; ud = ud_b; dout = do_b; dep = DB; af = AFB; dv = d;
    end else begin
      st = m_a; ov = ov_a; ud = ud_a; dout = do_a; dep = DA; af = AFA; dv = {8'h00, d[7:0]};
    end
    @(negedge clk);
    a_push = !sel && ph; a_pop = !sel && pp; a_clear = !sel && cl; a_errclr = !sel && ec;
    b_push = sel && ph;  b_pop = sel && pp;  b_clear = sel && cl;  b_errclr = sel && ec;
    a_din  = d[7:0];
    b_din  = d;
    if (ec) begin
      ov = 1'b0; ud = 1'b0;
    end
    if (cl) begin
      st.delete();
    end else if (ph && pp) begin
      if (st.size() > 0) begin
        e = st[st.size()-1];
        st[st.size()-1] = dv;
      end else begin
        e = dv;
      end
      dout = e;
      if (sel) sb_b.push_back(e); else sb_a.push_back(e);
    end else if (ph) begin
      if (st.size() < dep) st.push_back(dv);
      else ov = 1'b1;
    end else if (pp) begin
      if (st.size() > 0) begin
        e = st.pop_back();
        dout = e;
        if (sel) sb_b.push_back(e); else sb_a.push_back(e);
      end else begin
        ud = 1'b1;
      end
    end
    if (sel) begin
      m_b = st; ov_b = ov; ud_b = ud; do_b = dout;
    end else begin
      m_a = st; ov_a = ov; ud_a = ud; do_a = dout;
    end
    @(posedge clk);
    #2;
    if (sel) begin
      chk("b_count", {29'b0, b_cnt}, st.size());
      chk("b_empty", {31'b0, b_empty}, {31'b0, st.size() == 0});
      chk("b_full", {31'b0, b_full}, {31'b0, st.size() == dep});
      chk("b_almost_full", {31'b0, b_af}, {31'b0, st.size() >= af});
      chk("b_top", {16'b0, b_top}, (st.size() > 0) ? {16'b0, st[st.size()-1]} : 32'd0);
      chk("b_overflow", {31'b0, b_ovf}, {31'b0, ov});
      chk("b_underflow", {31'b0, b_udf}, {31'b0, ud});
      chk("b_data_out_hold", {16'b0, b_dout}, {16'b0, dout});
    end else begin
      chk("a_count", {28'b0, a_cnt}, st.size());
      chk("a_empty", {31'b0, a_empty}, {31'b0, st.size() == 0});
      chk("a_full", {31'b0, a_full}, {31'b0, st.size() == dep});
      chk("a_almost_full", {31'b0, a_af}, {31'b0, st.size() >= af});
      chk("a_top", {24'b0, a_top}, (st.size() > 0) ? {16'b0, st[st.size()-1]} : 32'd0);
      chk("a_overflow", {31'b0, a_ovf}, {31'b0, ov});
      chk("a_underflow", {31'b0, a_udf}, {31'b0, ud});
      chk("a_data_out_hold", {24'b0, a_dout}, {16'b0, dout});
    end
  endtask

  initial begin
    rst_n = 1'b1;
    a_push = 0; a_pop = 0; a_clear = 0; a_errclr = 0; a_din = '0;
    b_push = 0; b_pop = 0; b_clear = 0; b_errclr = 0; b_din = '0;
    model_reset();
    #1 rst_n = 1'b0;
    #1 check_reset_outputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill A with 0x01..0x08, then drain in reverse order
    for (int i = 1; i <= DA; i++) op(0, 1, 0, 0, 0, 16'(i));
    chk("fill_a_full", {31'b0, a_full}, 32'd1);
    // Overflow: refused push, sticky until err_clr
    op(0, 1, 0, 0, 0, 16'h00AA);
    chk("ovf_a_top_kept", {24'b0, a_top}, 32'h08);
    op(0, 0, 0, 0, 0, 16'h0);
    op(0, 0, 0, 0, 1, 16'h0);
    for (int i = 0; i < DA; i++) op(0, 0, 1, 0, 0, 16'h0);
    chk("drain_a_last", {24'b0, a_dout}, 32'h01);
    chk("drain_a_empty", {31'b0, a_empty}, 32'd1);

    // Underflow, err_clr together with a fresh error, then err_clr alone
    op(0, 0, 1, 0, 0, 16'h0);
    chk("udf_a_set", {31'b0, a_udf}, 32'd1);
    op(0, 0, 0, 0, 0, 16'h0);
    op(0, 0, 1, 0, 1, 16'h0);
    op(0, 0, 0, 0, 1, 16'h0);
    chk("udf_a_cleared", {31'b0, a_udf}, 32'd0);

    // Simultaneous push+pop with content and on an empty stack
    op(0, 1, 0, 0, 0, 16'h10);
    op(0, 1, 0, 0, 0, 16'h20);
    op(0, 1, 1, 0, 0, 16'h33);
    chk("swap_a_top", {24'b0, a_top}, 32'h33);
    chk("swap_a_dout", {24'b0, a_dout}, 32'h20);
    op(0, 0, 1, 0, 0, 16'h0);
    op(0, 0, 1, 0, 0, 16'h0);
    op(0, 1, 1, 0, 0, 16'h44);
    chk("pass_a_dout", {24'b0, a_dout}, 32'h44);
    chk("pass_a_count", {28'b0, a_cnt}, 32'd0);

    // Clear with push at count 5
    for (int i = 0; i < 5; i++) op(0, 1, 0, 0, 0, 16'h50 + 16'(i));
    op(0, 1, 0, 1, 0, 16'h77);
    chk("clear_a_count", {28'b0, a_cnt}, 32'd0);

    // Swap while full, a refused push to set overflow, then reset mid-burst
    for (int i = 0; i < DA; i++) op(0, 1, 0, 0, 0, 16'hC0 + 16'(i));
    op(0, 1, 1, 0, 0, 16'h55);
    op(0, 1, 0, 0, 0, 16'h66);
    op(0, 1, 0, 1, 0, 16'h0);
    for (int i = 0; i < 3; i++) op(0, 1, 0, 0, 0, 16'h90 + 16'(i));
    @(negedge clk);
    a_push = 1'b1; a_clear = 1'b0; a_din = 8'hE1;
    #2 rst_n = 1'b0;
    #1 check_reset_outputs();
    model_reset();
    a_push = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    op(0, 0, 0, 0, 0, 16'h0);

    // Instance B: fill/drain with a narrow depth and low almost_full level
    for (int i = 1; i <= DB; i++) op(1, 1, 0, 0, 0, 16'h1000 + 16'(i));
    chk("fill_b_full", {31'b0, b_full}, 32'd1);
    op(1, 1, 0, 0, 0, 16'hBEEF);
    for (int i = 0; i < DB; i++) op(1, 0, 1, 0, 0, 16'h0);
    chk("drain_b_last", {16'b0, b_dout}, 32'h1001);
    op(1, 0, 0, 0, 1, 16'h0);

    // Random traffic on both instances
    for (int i = 0; i < 150; i++)
      op(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
         $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0, 16'($urandom));
    for (int i = 0; i < 80; i++)
      op(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
         $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0, 16'($urandom));

    op(0, 0, 0, 0, 0, 16'h0);
    op(1, 0, 0, 0, 0, 16'h0);
    chk("sb_a_drained", sb_a.size(), 32'd0);
    chk("sb_b_drained", sb_b.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
